// File: rtl/signed_bcd_display.sv
// signed_bcd_display: converts a 16-bit two's-complement result into sign plus
// five BCD digits (sequential double-dabble, one shift per clock) and drives a
// 6-position multiplexed common-anode 7-segment display with leading-zero blanking.
module signed_bcd_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out,
  output logic        neg_out,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam int              CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   REF_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low glyph for one BCD digit; non-decimal codes show blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0]    state_r;
  logic          busy_r;
  logic          done_r;
  logic          sign_r;
  logic [15:0]   mag_r;
  logic [19:0]   scratch_r;
  logic [4:0]    cnt_r;
  logic [19:0]   bcd_r;
  logic          neg_r;
  logic [CW-1:0] refresh_r;
  logic [2:0]    sel_r;
  logic [5:0]    an_r;
  logic [6:0]    seg_r;

  logic [19:0]   adj_s;
  logic [15:0]   abs_s;
  logic [2:0]    sel_nxt_s;
  logic [6:0]    glyph_s;

  // Double-dabble correction: add 3 to every scratch nibble that is 5 or more.
  always_comb begin
    adj_s = scratch_r;
    for (int i = 0; i < 5; i++) begin
      if (scratch_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4];
      end
    end
  end

  // Magnitude of the input; 0x8000 naturally maps to 32768 in 16 unsigned bits.
  always_comb begin
    if (value_in[15]) begin
      abs_s = ~value_in + 16'd1;
    end else begin
      abs_s = value_in;
    end
  end

  // Conversion FSM: capture, 16 shift steps, then a one-cycle commit.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sign_r    <= 1'b0;
      mag_r     <= 16'd0;
      scratch_r <= 20'd0;
      cnt_r     <= 5'd0;
      bcd_r     <= 20'd0;
      neg_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            sign_r    <= value_in[15];
            mag_r     <= abs_s;
            scratch_r <= 20'd0;
            cnt_r     <= 5'd0;
            busy_r    <= 1'b1;
            state_r   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_r <= {adj_s[18:0], mag_r[15]};
          mag_r     <= {mag_r[14:0], 1'b0};
          cnt_r     <= cnt_r + 5'd1;
          if (cnt_r == 5'd15) begin
            busy_r  <= 1'b0;
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_r   <= scratch_r;
          neg_r   <= sign_r;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next digit position: advance only when the refresh counter wraps.
  always_comb begin
    if (refresh_r == REF_MAX) begin
      if (sel_r == 3'd5) begin
        sel_nxt_s = 3'd0;
      end else begin
        sel_nxt_s = sel_r + 3'd1;
      end
    end else begin
      sel_nxt_s = sel_r;
    end
  end

  // Glyph for the position being selected, with leading-zero blanking.
  always_comb begin
    glyph_s = SEG_BLANK;
    case (sel_nxt_s)
      3'd0: glyph_s = seg_of(bcd_r[3:0]);
      3'd1: glyph_s = (bcd_r[19:4]  == 16'd0) ? SEG_BLANK : seg_of(bcd_r[7:4]);
      3'd2: glyph_s = (bcd_r[19:8]  == 12'd0) ? SEG_BLANK : seg_of(bcd_r[11:8]);
      3'd3: glyph_s = (bcd_r[19:12] == 8'd0)  ? SEG_BLANK : seg_of(bcd_r[15:12]);
      3'd4: glyph_s = (bcd_r[19:16] == 4'd0)  ? SEG_BLANK : seg_of(bcd_r[19:16]);
      3'd5: glyph_s = neg_r ? SEG_DASH : SEG_BLANK;
      default: glyph_s = SEG_BLANK;
    endcase
  end

  // Free-running display multiplexer; anode and segments update together.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      refresh_r <= '0;
      sel_r     <= 3'd0;
      an_r      <= 6'b111110;
      seg_r     <= 7'b1000000;
    end else begin
      if (refresh_r == REF_MAX) begin
        refresh_r <= '0;
      end else begin
        refresh_r <= refresh_r + CW'(1);
      end
      sel_r <= sel_nxt_s;
      an_r  <= ~(6'b000001 << sel_nxt_s);
      seg_r <= glyph_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_r;
  assign neg_out = neg_r;
  assign seg_n   = seg_r;
  assign an_n    = an_r;

endmodule

// File: doc/signed_bcd_display.md
Name: signed_bcd_display

Overview:
- Downstream consumer of the calculator datapath's 16-bit signed two's-complement result (`display_output`, strobed by `complete`).
- Converts the result to sign plus five BCD digits using a sequential double-dabble: one shift per clock.
- Drives a 6-position, time-multiplexed, common-anode 7-segment display with leading-zero blanking.
- Digit 5 is the sign position; digits 4..0 are the magnitude, with digit 0 the least significant.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit position stays selected before the multiplexer advances; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- value_in  input  16  signed two's-complement value to display.
- load  input  1  capture request; sampled on clk; honoured only when busy=0.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when new digits are committed.
- bcd_out  output  20  committed magnitude: {d4,d3,d2,d1,d0}, 4 bits each.
- neg_out  output  1  committed sign: 1 = negative.
- seg_n  output  7  active-low segments in order {g,f,e,d,c,b,a}.
- an_n  output  6  active-low one-hot digit select; an_n[k] selects digit k.

Behaviour:
- Reset (asynchronous, any time): state=IDLE, busy=0, done=0, bcd_out=0, neg_out=0, refresh counter=0, digit select=0, an_n=6'b111110, seg_n=7'b1000000 ("0").
- States: IDLE, CONVERT, COMMIT.
- IDLE: load=1 at a clk edge does the following.
  - Capture sign = value_in[15].
  - Capture magnitude = |value_in| as a 16-bit unsigned value; -32768 (0x8000) yields magnitude 32768.
  - Clear the 20-bit BCD scratch register and the shift counter.
  - Go to CONVERT; busy=1 from the next cycle.
- CONVERT: each cycle does the following.
  - Add 3 to every scratch nibble that is ≥ 5 (combinational).
  - Shift {scratch, magnitude} left by 1 and increment the counter.
  - After the 16th shift, go to COMMIT.
- COMMIT, one cycle:
  - Write bcd_out and neg_out; assert done=1 for exactly this cycle.
  - busy=0 while in COMMIT; return to IDLE.
  - If load=1 in COMMIT, it is ignored.
- Latency: load accepted at edge E → done high during the cycle after edge E+17, with bcd_out/neg_out updated at that same edge. Back-to-back minimum spacing is 18 cycles.
- load while busy=1: ignored, not queued.
- Zero: neg_out=0 always; -0 cannot occur.
- Committed outputs hold until the next COMMIT or reset. The display always shows the committed values, never partial scratch values.
- Multiplexer runs continuously, independent of the conversion FSM:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps to 0 and advances the digit select 0→1→…→5→0.
  - an_n and seg_n are registered and change on the same edge.
- Per-digit glyph:
  - Digit 0: always shows its BCD value.
  - Digit k (1..4): blank if it and all higher magnitude digits are 0, otherwise its BCD value.
  - Digit 5: "-" if neg_out=1, else blank.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - "-"=0111111, blank=1111111.
- Reset mid-CONVERT: conversion is abandoned and done never pulses; committed outputs return to their reset values.

Test Plan:
- Reset, then load value_in=12:
  - done pulses once, exactly 17 edges after the accepting edge.
  - bcd_out=20'h00012, neg_out=0; busy high for exactly 16 cycles.
- load value_in=16'hFFF7 (-9) → bcd_out=20'h00009, neg_out=1. Values 16'h8000 → 20'h32768/neg 1; 16'h7FFF → 20'h32767/neg 0; 0 → 20'h00000/neg 0.
- REFRESH_DIV=4, committed -12:
  - an_n steps 111110→111101→…→011111 every 4 clocks and wraps.
  - seg_n per position: d0=0100100, d1=1111001, d2–d4=1111111, d5=0111111.
- Committed 7 → d0=1111000; d1–d5 blank. Committed 0 → d0=1000000; others blank.
- Pulse load during CONVERT with a different value → ignored; result reflects the first value; only one done pulse.
- Assert nRST 5 cycles into CONVERT, release, wait 30 cycles → no done; bcd_out=0, neg_out=0, an_n=111110 immediately on reset.
